rgst_seq_shifter: RTL

Parametrised sequential shift register with multi-bit shift capability.
- Performs multi-bit shifts and rotates one bit per clock, under a start/busy/done handshake.
- Captures the last shifted-out bit in carry_out.
- Used by the ALU datapath for shift instructions and by the iterative multiply/divide sequencers.
- Generalises the single-step load/shift register with five shift modes, a shift counter and completion signalling.

---
 rtl/rgst_seq_shifter.sv | 111 +++++++++++
 1 files changed

// File: rtl/rgst_seq_shifter.sv
// Sequential multi-bit shifter: performs one shift/rotate step per clock under
// a start/busy/done handshake, keeping the last shifted-out bit in carry_out.
//
// state    | meaning
// ST_IDLE  | accepts parallel load and start
// ST_SHIFT | one step per clock until the counter reaches its terminal count
// ST_DONE  | one-cycle completion pulse, inputs ignored
module rgst_seq_shifter #(
  parameter int WIDTH = 8,
  parameter int AMT_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_enable,
  input  logic [WIDTH-1:0] data_in,
  input  logic             start,
  input  logic [2:0]       mode,
  input  logic [AMT_W-1:0] amount,
  input  logic             serial_in,
  output logic [WIDTH-1:0] data_out,
  output logic             carry_out,
  output logic             busy,
  output logic             done
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  localparam logic [2:0] MODE_LSL = 3'b000;
  localparam logic [2:0] MODE_LSR = 3'b001;
  localparam logic [2:0] MODE_ASR = 3'b010;
  localparam logic [2:0] MODE_ROL = 3'b011;
  localparam logic [2:0] MODE_ROR = 3'b100;

  logic [1:0]       state;
  logic [AMT_W-1:0] counter;
  logic [2:0]       mode_q;
  logic [WIDTH-1:0] step_data;
  logic             step_carry;
  logic             step_valid;

  always_comb begin
    step_data  = data_out;
    step_carry = carry_out;
    step_valid = 1'b1;
    case (mode_q)
      MODE_LSL: begin
        step_data  = {data_out[WIDTH-2:0], serial_in};
        step_carry = data_out[WIDTH-1];
      end
      MODE_LSR: begin
        step_data  = {serial_in, data_out[WIDTH-1:1]};
        step_carry = data_out[0];
      end
      MODE_ASR: begin
        step_data  = {data_out[WIDTH-1], data_out[WIDTH-1:1]};
        step_carry = data_out[0];
      end
      MODE_ROL: begin
        step_data  = {data_out[WIDTH-2:0], data_out[WIDTH-1]};
        step_carry = data_out[WIDTH-1];
      end
      MODE_ROR: begin
        step_data  = {data_out[0], data_out[WIDTH-1:1]};
        step_carry = data_out[0];
      end
      default: step_valid = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_IDLE;
      counter   <= '0;
      mode_q    <= '0;
      data_out  <= '0;
      carry_out <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (load_enable) data_out <= data_in;
          if (start) begin
            mode_q <= mode;
            if (amount != '0) begin
              counter <= amount;
              state   <= ST_SHIFT;
            end else begin
              state <= ST_DONE;
            end
          end
        end
        ST_SHIFT: begin
          // reserved modes hold data but still burn the counter
          if (step_valid) begin
            data_out  <= step_data;
            carry_out <= step_carry;
          end
          counter <= counter - 1'b1;
          if (counter == AMT_W'(1)) state <= ST_DONE;
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign busy = (state == ST_SHIFT);
  assign done = (state == ST_DONE);

endmodule
